// File: rtl/nes_joypad_poller.sv
// NES joypad poller: periodically latches and clocks a physical NES controller,
// shifts in its 8 active-low button bits plus a presence bit, and presents an
// active-high button byte with a one-cycle valid pulse to the core side.
`timescale 1ns/1ps

module nes_joypad_poller #(
    parameter int unsigned C_clk_hz  = 21477272,
    parameter int unsigned C_poll_hz = 60,
    parameter int unsigned C_half_us = 6
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_enable,
    input  logic       i_joy_data,
    output logic       o_joy_strobe,
    output logic       o_joy_clock,
    output logic [7:0] o_buttons,
    output logic       o_present,
    output logic       o_valid
);

    // Derived timing: poll period P and half-bit time T in clock cycles
    localparam longint P_RAW = longint'(C_clk_hz) / longint'(C_poll_hz);
    localparam longint T_RAW = longint'(C_clk_hz) * longint'(C_half_us) / longint'(1000000);
    localparam int     P     = (P_RAW < 1) ? 1 : int'(P_RAW);
    localparam int     T     = (T_RAW < 1) ? 1 : int'(T_RAW);
    localparam int     TWO_T = 2 * T;
    localparam int     PW    = (P > 1) ? $clog2(P) : 1;
    localparam int     TW    = $clog2(TWO_T);

    localparam logic [PW-1:0] P_LAST     = PW'(P - 1);
    localparam logic [TW-1:0] T_LAST     = TW'(T - 1);
    localparam logic [TW-1:0] TWO_T_LAST = TW'(TWO_T - 1);
    localparam logic [3:0]    LAST_BIT   = 4'd8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   pollCnt_q;
    logic [TW-1:0]   phase_q, phase_d;
    logic [3:0]      bit_q, bit_d;
    logic [7:0]      shift_q;
    logic            presentRaw_q;
    logic            sync1_q, sync2_q;
    logic            strobe_q, clk_q, valid_q, present_q;
    logic [7:0]      buttons_q;
    logic            tick;
    logic            sampleNow;

    assign tick      = (pollCnt_q == P_LAST);
    assign sampleNow = (state_q == S_LOW) && (phase_q == T_LAST);

    // Two-flop synchroniser for the asynchronous pad data line (idles high via pull-up)
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= i_joy_data;
            sync2_q <= sync1_q;
        end
    end

    // Free-running poll counter; its wrap is the scan-start tick
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pollCnt_q <= '0;
        end else if (tick) begin
            pollCnt_q <= '0;
        end else begin
            pollCnt_q <= pollCnt_q + PW'(1);
        end
    end

    // State, phase timer and bit index registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
        end
    end

    // Next-state logic: strobe for 2T, then 9 low phases interleaved with 8 clock-high phases
    always_comb begin
        state_d = state_q;
        phase_d = phase_q + TW'(1);
        bit_d   = bit_q;
        unique case (state_q)
            S_IDLE: begin
                phase_d = '0;
                if (tick && i_enable) begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                if (phase_q == TWO_T_LAST) begin
                    state_d = S_LOW;
                    phase_d = '0;
                    bit_d   = '0;
                end
            end
            S_LOW: begin
                if (phase_q == T_LAST) begin
                    phase_d = '0;
                    state_d = (bit_q == LAST_BIT) ? S_DONE : S_HIGH;
                end
            end
            S_HIGH: begin
                if (phase_q == T_LAST) begin
                    state_d = S_LOW;
                    phase_d = '0;
                    bit_d   = bit_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                phase_d = '0;
            end
            default: begin
                state_d = S_IDLE;
                phase_d = '0;
            end
        endcase
    end

    // Capture inverted pad data at the end of each low phase; bit 8 is the presence bit
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_q      <= '0;
            presentRaw_q <= 1'b0;
        end else if (state_q == S_IDLE && state_d == S_LATCH) begin
            shift_q      <= '0;
            presentRaw_q <= 1'b0;
        end else if (sampleNow) begin
            if (bit_q < LAST_BIT) begin
                shift_q[bit_q[2:0]] <= ~sync2_q;
            end else begin
                presentRaw_q <= ~sync2_q;
            end
        end
    end

    // Registered pad pins and core-side results; results only change when a scan completes
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            strobe_q  <= 1'b0;
            clk_q     <= 1'b0;
            valid_q   <= 1'b0;
            buttons_q <= '0;
            present_q <= 1'b0;
        end else begin
            strobe_q <= (state_d == S_LATCH);
            clk_q    <= (state_d == S_HIGH);
            valid_q  <= (state_q == S_DONE);
            if (state_q == S_DONE) begin
                buttons_q <= presentRaw_q ? shift_q : 8'h00;
                present_q <= presentRaw_q;
            end
        end
    end

    assign o_joy_strobe = strobe_q;
    assign o_joy_clock  = clk_q;
    assign o_buttons    = buttons_q;
    assign o_present    = present_q;
    assign o_valid      = valid_q;

endmodule
